// File: rtl/prg_load_seq.sv
// PRG download sequencer: parses the load-address header, streams payload into the core config
// port through a one-entry holding register, then patches the BASIC end pointers. Macro: PRG_AUTORUN_EN.
module prg_load_seq #(
   parameter logic [15:0] ADDR_LIMIT = 16'hA000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [7:0]  dl_dout,
   output logic        dl_wait,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_wr,
   input  logic        mem_busy,
   output logic [15:0] load_end,
   output logic        overflow,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PATCH, DONE} state_t;

`ifdef PRG_AUTORUN_EN
   localparam logic [3:0] NPATCH = 4'd13;
`else
   localparam logic [3:0] NPATCH = 4'd8;
`endif

   state_t      state;
   logic        act_q;
   logic [15:0] addr;
   logic [3:0]  pidx;
   logic        accept;
   logic        full_busy;
   logic        act_rise;

   assign accept    = mem_wr && !mem_busy;
   assign full_busy = mem_wr && mem_busy;
   assign act_rise  = dl_active && !act_q;
   // A byte can only collide with the holding register while the core is stalling it.
   assign dl_wait   = full_busy;

   function automatic logic [15:0] patch_addr(input logic [3:0] i);
      logic [15:0] a;
      case (i)
         4'd0:    a = 16'h002D;
         4'd1:    a = 16'h002E;
         4'd2:    a = 16'h002F;
         4'd3:    a = 16'h0030;
         4'd4:    a = 16'h0031;
         4'd5:    a = 16'h0032;
         4'd6:    a = 16'h00AE;
         4'd7:    a = 16'h00AF;
`ifdef PRG_AUTORUN_EN
         4'd8:    a = 16'h0277;
         4'd9:    a = 16'h0278;
         4'd10:   a = 16'h0279;
         4'd11:   a = 16'h027A;
         4'd12:   a = 16'h00C6;
`endif
         default: a = 16'h0000;
      endcase
      return a;
   endfunction

   function automatic logic [7:0] patch_data(input logic [3:0] i, input logic [15:0] le);
      logic [7:0] d;
      case (i)
         4'd0, 4'd2, 4'd4, 4'd6: d = le[7:0];
         4'd1, 4'd3, 4'd5, 4'd7: d = le[15:8];
`ifdef PRG_AUTORUN_EN
         4'd8:    d = 8'h52;
         4'd9:    d = 8'h55;
         4'd10:   d = 8'h4E;
         4'd11:   d = 8'h0D;
         4'd12:   d = 8'h04;
`endif
         default: d = 8'h00;
      endcase
      return d;
   endfunction

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         act_q    <= 1'b0;
         addr     <= 16'h0000;
         pidx     <= 4'd0;
         mem_addr <= 16'h0000;
         mem_data <= 8'h00;
         mem_wr   <= 1'b0;
         load_end <= 16'h0000;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         act_q <= dl_active;
         done  <= 1'b0;
         // An accepted write empties the register unless a later branch refills it.
         if (accept) mem_wr <= 1'b0;
         case (state)
            IDLE: begin
               if (act_rise) begin
                  state    <= HDR_LO;
                  overflow <= 1'b0;
                  mem_wr   <= 1'b0;
                  mem_addr <= 16'h0000;
                  mem_data <= 8'h00;
               end
            end
            HDR_LO: begin
               if (!dl_active) begin
                  state <= IDLE;
               end else if (dl_wr) begin
                  addr[7:0] <= dl_dout;
                  state     <= HDR_HI;
               end
            end
            HDR_HI: begin
               if (!dl_active) begin
                  state <= IDLE;
               end else if (dl_wr) begin
                  addr[15:8] <= dl_dout;
                  state      <= DATA;
               end
            end
            DATA: begin
               if (dl_wr) begin
                  if (full_busy) begin
                     overflow <= 1'b1;
                  end else if (addr < ADDR_LIMIT) begin
                     mem_addr <= addr;
                     mem_data <= dl_dout;
                     mem_wr   <= 1'b1;
                     addr     <= addr + 16'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end else if (!dl_active && (!mem_wr || accept)) begin
                  state    <= PATCH;
                  load_end <= addr;
                  pidx     <= 4'd0;
               end
            end
            PATCH: begin
               if (!mem_wr || accept) begin
                  if (dl_active) begin
                     state    <= HDR_LO;
                     overflow <= 1'b0;
                  end else if (pidx < NPATCH) begin
                     mem_addr <= patch_addr(pidx);
                     mem_data <= patch_data(pidx, load_end);
                     mem_wr   <= 1'b1;
                     pidx     <= pidx + 4'd1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (dl_active) begin
                  state    <= HDR_LO;
                  overflow <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
